audio_spi_sequencer: RTL



---
 rtl/audio_spi_sequencer.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_spi_sequencer.sv
// Single SPI master for the audio path: preamp gain, dual-channel ADC capture and
// 1..4 DAC channel writes share one sck/mosi bus under one frame-driven state machine.
module audio_spi_sequencer #(
    parameter int CLK_DIV      = 2,
    parameter int SAMPLE_DIV   = 2000,
    parameter int DAC_CHANNELS = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        miso,
    input  logic [1:0]  mode,
    input  logic [47:0] dacin,
    input  logic [3:0]  gaina,
    input  logic [3:0]  gainb,
    input  logic        startgain,
    output logic        sck,
    output logic        mosi,
    output logic        adconv,
    output logic        ampcs,
    output logic        ampshdn,
    output logic        daccs,
    output logic        dacclr,
    output logic        spissb,
    output logic        sf_ce0,
    output logic        fpgainitb,
    output logic [13:0] adca,
    output logic [13:0] adcb,
    output logic        samplevalid,
    output logic        busy,
    output logic        overrun
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SAMPLE_DIV - 1);
    localparam logic [1:0]    LAST_CH   = 2'(DAC_CHANNELS - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0, ST_GAIN = 3'd1, ST_IDLE = 3'd2,
        ST_CONV = 3'd3, ST_ADC  = 3'd4, ST_DAC  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [5:0]    per_cnt_q, per_cnt_d;
    logic [1:0]    ch_q, ch_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    gain_word_q, gain_word_d;
    logic [13:0]   sa_q, sa_d, sb_q, sb_d;
    logic [13:0]   adca_q, adca_d, adcb_q, adcb_d;
    logic          sv_q, sv_d;
    logic [1:0]    mode_q, mode_d;
    logic [47:0]   dacin_q, dacin_d;
    logic          sck_q, sck_d, mosi_q, mosi_d, adconv_q, adconv_d;
    logic          ampcs_q, ampcs_d, daccs_q, daccs_d, dacclr_q, busy_q, busy_d;

    logic          tick_s, per_end_s, sck_hi_s, enter_s, dac_entry_s, adc_sample_s;
    logic [11:0]   dac_code_s;
    logic [31:0]   dac_word_s;
    logic [13:0]   pass_s;

    assign tick_s      = (timer_q == LAST_TICK);
    assign per_end_s   = (clk_cnt_q == LAST_CNT);
    assign sck_hi_s    = (clk_cnt_q >= HALF_CNT);
    assign enter_s     = (state_d != state_q);
    assign dac_entry_s = (state_q == ST_ADC) && (state_d == ST_DAC);
    // miso is taken on the same clock edge that raises the registered sck
    assign adc_sample_s = (state_q == ST_ADC) && (clk_cnt_q == HALF_CNT);

    // State register and all datapath flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            clk_cnt_q   <= '0;
            per_cnt_q   <= 6'd0;
            ch_q        <= 2'd0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            overrun_q   <= 1'b0;
            gain_word_q <= 8'h00;
            sa_q        <= 14'h0000;
            sb_q        <= 14'h0000;
            adca_q      <= 14'h0000;
            adcb_q      <= 14'h0000;
            sv_q        <= 1'b0;
            mode_q      <= 2'b00;
            dacin_q     <= 48'h0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            adconv_q    <= 1'b0;
            ampcs_q     <= 1'b1;
            daccs_q     <= 1'b1;
            dacclr_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            per_cnt_q   <= per_cnt_d;
            ch_q        <= ch_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            gain_word_q <= gain_word_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            adca_q      <= adca_d;
            adcb_q      <= adcb_d;
            sv_q        <= sv_d;
            mode_q      <= mode_d;
            dacin_q     <= dacin_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            adconv_q    <= adconv_d;
            ampcs_q     <= ampcs_d;
            daccs_q     <= daccs_d;
            dacclr_q    <= 1'b1;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; a pending gain request wins over a frame tick in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_GAIN;
            ST_GAIN: begin
                if (per_end_s && (per_cnt_q == 6'd8)) state_d = ST_IDLE;
                else                                  state_d = ST_GAIN;
            end
            ST_IDLE: begin
                if (pend_q)      state_d = ST_GAIN;
                else if (tick_s) state_d = ST_CONV;
                else             state_d = ST_IDLE;
            end
            ST_CONV: begin
                if (per_end_s) state_d = ST_ADC;
                else           state_d = ST_CONV;
            end
            ST_ADC: begin
                if (per_end_s && (per_cnt_q == 6'd33)) state_d = ST_DAC;
                else                                   state_d = ST_ADC;
            end
            ST_DAC: begin
                if (per_end_s && (per_cnt_q == 6'd32) && (ch_q == LAST_CH)) state_d = ST_IDLE;
                else                                                        state_d = ST_DAC;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Counters, request/overrun tracking, ADC shifting and frame-entry sampling.
    always_comb begin
        if (enter_s || (state_q == ST_IDLE) || per_end_s) clk_cnt_d = '0;
        else                                               clk_cnt_d = clk_cnt_q + 1'b1;

        if (enter_s)                                           per_cnt_d = 6'd0;
        else if (per_end_s && (state_q == ST_DAC) && (per_cnt_q == 6'd32)) per_cnt_d = 6'd0;
        else if (per_end_s)                                    per_cnt_d = per_cnt_q + 6'd1;
        else                                                   per_cnt_d = per_cnt_q;

        if (enter_s)                                                         ch_d = 2'd0;
        else if ((state_q == ST_DAC) && per_end_s && (per_cnt_q == 6'd32))   ch_d = ch_q + 2'd1;
        else                                                                 ch_d = ch_q;

        if (tick_s) timer_d = '0;
        else        timer_d = timer_q + 1'b1;

        if (enter_s && (state_d == ST_GAIN)) begin
            pend_d      = 1'b0;
            gain_word_d = {gainb, gaina};
        end else begin
            pend_d      = pend_q | startgain;
            gain_word_d = gain_word_q;
        end

        overrun_d = overrun_q | (tick_s & ((state_q != ST_IDLE) | pend_q));

        if (adc_sample_s && (per_cnt_q >= 6'd2) && (per_cnt_q <= 6'd15)) sa_d = {sa_q[12:0], miso};
        else                                                              sa_d = sa_q;
        if (adc_sample_s && (per_cnt_q >= 6'd18) && (per_cnt_q <= 6'd31)) sb_d = {sb_q[12:0], miso};
        else                                                               sb_d = sb_q;

        sv_d = dac_entry_s;
        if (dac_entry_s) begin
            adca_d  = sa_q;
            adcb_d  = sb_q;
            mode_d  = mode;
            dacin_d = dacin;
        end else begin
            adca_d  = adca_q;
            adcb_d  = adcb_q;
            mode_d  = mode_q;
            dacin_d = dacin_q;
        end
    end

    // DAC code selection: passthrough converts two's complement to offset binary.
    always_comb begin
        if (ch_q[0]) pass_s = adcb_q;
        else         pass_s = adca_q;
        case (mode_q)
            2'b00: dac_code_s = {~pass_s[13], pass_s[12:2]};
            2'b01: begin
                case (ch_q)
                    2'd0:    dac_code_s = dacin_q[11:0];
                    2'd1:    dac_code_s = dacin_q[23:12];
                    2'd2:    dac_code_s = dacin_q[35:24];
                    default: dac_code_s = dacin_q[47:36];
                endcase
            end
            default: dac_code_s = 12'h800;
        endcase
        dac_word_s = {8'h00, 4'b0011, 2'b00, ch_q, dac_code_s, 4'h0};
    end

    // Bus outputs, all registered so every edge lands on an sck-low boundary.
    always_comb begin
        sck_d    = 1'b0;
        mosi_d   = 1'b0;
        adconv_d = 1'b0;
        ampcs_d  = 1'b1;
        daccs_d  = 1'b1;
        case (state_q)
            ST_GAIN: begin
                if (per_cnt_q < 6'd8) begin
                    ampcs_d = 1'b0;
                    sck_d   = sck_hi_s;
                    mosi_d  = gain_word_q[3'd7 - per_cnt_q[2:0]];
                end else begin
                    ampcs_d = 1'b1;
                end
            end
            ST_CONV: adconv_d = 1'b1;
            ST_ADC:  sck_d = sck_hi_s;
            ST_DAC: begin
                if (per_cnt_q < 6'd32) begin
                    daccs_d = 1'b0;
                    sck_d   = sck_hi_s;
                    mosi_d  = dac_word_s[5'd31 - per_cnt_q[4:0]];
                end else begin
                    daccs_d = 1'b1;
                end
            end
            default: sck_d = 1'b0;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign adconv      = adconv_q;
    assign ampcs       = ampcs_q;
    assign ampshdn     = 1'b0;
    assign daccs       = daccs_q;
    assign dacclr      = dacclr_q;
    assign spissb      = 1'b1;
    assign sf_ce0      = 1'b1;
    assign fpgainitb   = 1'b1;
    assign adca        = adca_q;
    assign adcb        = adcb_q;
    assign samplevalid = sv_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
endmodule
